ysyx_22040088_imem_slave: RTL and testbench

//  Memory-side responder for instruction fetch: accepts fetch addresses from the IFU over a

---
 rtl/ysyx_22040088_imem_slave.sv | 185 ++++++++++++++++++
 tb/tb_ysyx_22040088_imem_slave.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040088_imem_slave.sv
// ysyx_22040088_imem_slave
// Instruction-fetch responder. It accepts one fetch address at a time and returns
// the aligned 64-bit doubleword that holds it after a fixed number of cycles. The
// IFU picks the 32-bit instruction out of that doubleword.
// The backing store is a doubleword array with no reset, filled through the load port.
// Response errors: 01 = address not word aligned, 10 = outside the array window.
// Misalignment takes priority over the range check.

module ysyx_22040088_imem_slave #(
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [63:0]           req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [63:0]           resp_data,
    output logic [1:0]            resp_err,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_idx,
    input  logic [63:0]           load_data,
    output logic [31:0]           fetch_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // The counter is preset to LATENCY-1 on accept. The capture happens on the
    // edge where it reads zero, so resp_valid rises exactly LATENCY edges after
    // the accept edge.
    localparam logic [3:0] WAIT_PRESET = 4'(LATENCY - 1);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [63:0]             addr_reg;
    logic [63:0]             addr_next;
    logic [3:0]              wait_cnt_reg;
    logic [3:0]              wait_cnt_next;
    logic [63:0]             resp_data_reg;
    logic [1:0]              resp_err_reg;
    logic [31:0]             fetch_cnt_reg;

    logic                    req_fire;
    logic                    resp_fire;
    logic                    capture;

    logic [63:0]             idx_full;
    logic                    misaligned;
    logic                    below_base;
    logic                    beyond_top;
    logic [1:0]              err_code;
    logic [DEPTH_LOG2-1:0]   rd_idx;

    logic [63:0]             mem [DEPTH];

    assign req_fire  = req_valid && (state_reg == ST_IDLE);
    assign resp_fire = resp_ready && (state_reg == ST_RESP);
    assign capture   = (state_reg == ST_WAIT) && (wait_cnt_reg == 4'd0);

    // Address decode works on the latched address. The full 64-bit index is kept
    // so that a large address cannot wrap back into the window.
    assign idx_full   = (addr_reg - BASE_ADDR) >> 3;
    assign misaligned = |addr_reg[1:0];
    assign below_base = addr_reg < BASE_ADDR;
    assign beyond_top = (idx_full >> DEPTH_LOG2) != 64'd0;
    assign rd_idx     = idx_full[DEPTH_LOG2-1:0];

    // Error classification: misalignment first, then range.
    always_comb begin
        err_code = ERR_OK;
        if (misaligned) begin
            err_code = ERR_ALIGN;
        end else if (below_base || beyond_top) begin
            err_code = ERR_RANGE;
        end
    end

    // Preload port. Writes are allowed in every state. The array is not reset, so
    // it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_idx] <= load_data;
        end
    end

    // State, latched address and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Next-state logic: IDLE -> WAIT on accept, WAIT -> RESP on capture,
    // RESP -> IDLE on handshake.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_fire) begin
                    state_next    = ST_WAIT;
                    addr_next     = req_addr;
                    wait_cnt_next = WAIT_PRESET;
                end
            end
            ST_WAIT: begin
                if (capture) begin
                    state_next = ST_RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_fire) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output logic: both handshake signals are pure state decodes.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            ST_IDLE: req_ready  = 1'b1;
            ST_RESP: resp_valid = 1'b1;
            default: begin
                req_ready  = 1'b0;
                resp_valid = 1'b0;
            end
        endcase
    end

    // Response capture. The array read happens on the capture edge itself, so a
    // load landing on that same edge is not seen: the old value is returned.
    // The registers hold their values after the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_data_reg <= '0;
            resp_err_reg  <= ERR_OK;
        end else if (capture) begin
            resp_err_reg  <= err_code;
            resp_data_reg <= (err_code == ERR_OK) ? mem[rd_idx] : 64'd0;
        end
    end

    // Completed-response counter. Error responses are counted too. It saturates
    // rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_reg <= '0;
        end else if (resp_fire && (fetch_cnt_reg != 32'hFFFF_FFFF)) begin
            fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
        end
    end

    assign resp_data = resp_data_reg;
    assign resp_err  = resp_err_reg;
    assign fetch_cnt = fetch_cnt_reg;

endmodule

// File: tb/tb_ysyx_22040088_imem_slave.sv
// Bench for ysyx_22040088_imem_slave: one instance with LATENCY=2 and one with LATENCY=1.
// Expected responses come from a byte-address reference model with its own copy of the array.

module tb_ysyx_22040088_imem_slave;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          NENT  = 4096;
    localparam int          LAT0  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req_valid, req_ready, resp_valid, resp_ready, load_en;
    logic [63:0] req_addr, resp_data, load_data;
    logic [1:0]  resp_err;
    logic [11:0] load_idx;
    logic [31:0] fetch_cnt;

    logic        req_valid1, req_ready1, resp_valid1, resp_ready1, load_en1;
    logic [63:0] req_addr1, resp_data1, load_data1;
    logic [1:0]  resp_err1;
    logic [11:0] load_idx1;
    logic [31:0] fetch_cnt1;

    logic [63:0] mem0 [NENT];
    logic [63:0] mem1 [NENT];
    int          cnt0 = 0;
    int          cnt1 = 0;
    int          checks = 0;
    int          errors = 0;

    ysyx_22040088_imem_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(12), .LATENCY(LAT0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err), .load_en(load_en), .load_idx(load_idx),
        .load_data(load_data), .fetch_cnt(fetch_cnt)
    );

    ysyx_22040088_imem_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(12), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_data(resp_data1),
        .resp_err(resp_err1), .load_en(load_en1), .load_idx(load_idx1),
        .load_data(load_data1), .fetch_cnt(fetch_cnt1)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model. A fetch is judged on its byte address: not word aligned,
    // then outside [BASE, BASE + 8*NENT), otherwise the doubleword containing it.
    task automatic ref_resp(input bit sel, input logic [63:0] a,
                            output logic [63:0] d, output logic [1:0] e);
        d = 64'd0;
        if (a % 4 != 0) begin
            e = 2'b01;
        end else if (a < BASE || a >= BASE + 64'(8 * NENT)) begin
            e = 2'b10;
        end else begin
            e = 2'b00;
            d = sel ? mem1[(a - BASE) / 8] : mem0[(a - BASE) / 8];
        end
    endtask

    function automatic int rand_idx();
        return ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 31))
                                           : int'($urandom_range(NENT - 32, NENT - 1));
    endfunction

    task automatic load0(input int idx, input logic [63:0] d);
        load_en = 1'b1; load_idx = 12'(idx); load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
        mem0[idx] = d;
    endtask

    task automatic load1(input int idx, input logic [63:0] d);
        load_en1 = 1'b1; load_idx1 = 12'(idx); load_data1 = d;
        @(posedge clk); #1;
        load_en1 = 1'b0;
        mem1[idx] = d;
    endtask

    // One complete fetch on the LATENCY=2 instance.
    // delay: cycles to hold resp_ready low in RESP. poke: present a request during
    // RESP, which must not be taken. wait_load: overwrite the target entry during WAIT.
    task automatic fetch0(input logic [63:0] addr, input int delay,
                          input bit poke, input bit wait_load);
        logic [63:0] ed, held;
        logic [1:0]  ee;
        int          cyc;
        check("idle_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_addr = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("wait_ready_low", 64'(req_ready), 64'd0);
        if (wait_load) begin
            load_en = 1'b1; load_idx = 12'((addr - BASE) / 8); load_data = {$urandom, $urandom};
            mem0[(addr - BASE) / 8] = load_data;
        end
        cyc = 0;
        while (!resp_valid && cyc < 20) begin
            @(posedge clk); #1;
            load_en = 1'b0;
            cyc++;
        end
        load_en = 1'b0;
        ref_resp(1'b0, addr, ed, ee);
        check("latency", 64'(cyc), 64'(LAT0));
        check("resp_data", resp_data, ed);
        check("resp_err", 64'(resp_err), 64'(ee));
        held = resp_data;
        for (int k = 0; k < delay; k++) begin
            if (poke) begin
                req_valid = 1'b1; req_addr = addr + 64'd8;
            end
            @(posedge clk); #1;
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_data", resp_data, held);
            check("hold_ready_low", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        check("hs_ready_low", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        cnt0++;
        check("post_valid", 64'(resp_valid), 64'd0);
        check("post_data_kept", resp_data, held);
        check("fetch_cnt", 64'(fetch_cnt), 64'(cnt0));
        check("post_ready", 64'(req_ready), 64'd1);
        $display("fetch0 addr=%h err=%0d data=%h delay=%0d cnt=%0d", addr, ee, ed, delay, cnt0);
    endtask

    initial begin
        logic [63:0] a, old_d, ed;
        logic [1:0]  ee;
        int          last, nresp, issued, idx;
        logic [63:0] exp_d_q[$];
        logic [1:0]  exp_e_q[$];

        req_valid = 0; req_addr = 0; resp_ready = 0; load_en = 0; load_idx = 0; load_data = 0;
        req_valid1 = 0; req_addr1 = 0; resp_ready1 = 0; load_en1 = 0; load_idx1 = 0; load_data1 = 0;

        // Reset values while reset is held
        #13;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Preload both arrays at the low and high ends of the window
        for (int i = 0; i < 32; i++) begin
            load0(i, {$urandom, $urandom});
            load0(NENT - 32 + i, {$urandom, $urandom});
            load1(i, {$urandom, $urandom});
        end
        load0(0, 64'h0000_0513_0000_0093);

        // Directed fetches: aligned, upper word, misaligned, both sides of the window
        fetch0(64'h8000_0000, 0, 1'b0, 1'b0);
        fetch0(64'h8000_0004, 1, 1'b0, 1'b0);
        fetch0(64'h8000_0002, 0, 1'b0, 1'b0);
        fetch0(64'h7FFF_FFF8, 0, 1'b0, 1'b0);
        fetch0(64'h8000_8000, 0, 1'b0, 1'b0);
        fetch0(64'h8000_7FF8, 0, 1'b0, 1'b0);
        fetch0(64'h7FFF_FFF9, 0, 1'b0, 1'b0);
        fetch0(64'h8000_0008, 5, 1'b1, 1'b0);
        fetch0(64'h8000_0038, 0, 1'b0, 1'b1);

        // Randomized fetches, with occasional loads between them
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 5))
                0: a = BASE + 64'(8 * rand_idx());
                1: a = BASE + 64'(8 * rand_idx()) + 64'd4;
                2: a = BASE + 64'(8 * rand_idx()) + 64'($urandom_range(1, 3));
                3: a = BASE - 64'(8 * $urandom_range(1, 100));
                4: a = BASE + 64'(8 * NENT) + 64'(8 * $urandom_range(0, 1000));
                default: a = {1'b1, 31'($urandom), 29'($urandom), 3'b000};
            endcase
            if ($urandom_range(0, 3) == 0) load0(rand_idx(), {$urandom, $urandom});
            fetch0(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   (a >= BASE) && (a < BASE + 64'(8 * NENT)) && (a % 8 == 0) &&
                   ($urandom_range(0, 1) != 0));
        end

        // Reset in the middle of WAIT
        req_valid = 1'b1; req_addr = BASE + 64'd16;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_valid", 64'(resp_valid), 64'd0);
        check("midrst_ready", 64'(req_ready), 64'd1);
        check("midrst_cnt", 64'(fetch_cnt), 64'd0);
        cnt0 = 0; cnt1 = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        nresp = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (resp_valid) nresp++;
        end
        check("midrst_no_resp", 64'(nresp), 64'd0);
        check("midrst_idle", 64'(req_ready), 64'd1);
        $display("reset-mid-wait: responses after release=%0d", nresp);

        // LATENCY=1: a load to the captured entry on the capture edge returns the old data
        old_d = mem1[5];
        req_valid1 = 1'b1; req_addr1 = BASE + 64'd40;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        load_en1 = 1'b1; load_idx1 = 12'd5; load_data1 = ~old_d;
        @(posedge clk); #1;
        load_en1 = 1'b0;
        mem1[5] = ~old_d;
        check("rbw_valid", 64'(resp_valid1), 64'd1);
        check("rbw_old_data", resp_data1, old_d);
        resp_ready1 = 1'b1;
        @(posedge clk); #1;
        resp_ready1 = 1'b0;
        cnt1++;
        $display("rbw fetch idx=5 data=%h", resp_data1);

        // LATENCY=1 back-to-back: one response every 3 cycles. The first refetches
        // entry 5, which must now return the new value.
        resp_ready1 = 1'b1;
        last = -1; nresp = 0; issued = 0;
        for (int c = 0; c < 40; c++) begin
            if (resp_valid1) begin
                ed = exp_d_q.pop_front();
                ee = exp_e_q.pop_front();
                check("b2b_data", resp_data1, ed);
                check("b2b_err", 64'(resp_err1), 64'(ee));
                if (last >= 0) check("b2b_interval", 64'(c - last), 64'd3);
                $display("b2b resp cycle=%0d err=%0d data=%h", c, resp_err1, resp_data1);
                last = c;
                nresp++;
                cnt1++;
            end
            if (req_ready1 && issued < 8) begin
                idx = int'($urandom_range(0, 31));
                a = (issued == 0) ? BASE + 64'd40
                                  : BASE + 64'(8 * idx) + 64'($urandom_range(0, 1) * 4)
                                    + (($urandom_range(0, 3) == 0) ? 64'd2 : 64'd0);
                ref_resp(1'b1, a, ed, ee);
                exp_d_q.push_back(ed);
                exp_e_q.push_back(ee);
                req_valid1 = 1'b1; req_addr1 = a;
                issued++;
            end else if (issued >= 8) begin
                req_valid1 = 1'b0;
            end
            @(posedge clk); #1;
        end
        resp_ready1 = 1'b0;
        check("b2b_count", 64'(nresp), 64'd8);
        check("b2b_fetch_cnt", 64'(fetch_cnt1), 64'(cnt1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
